// File: rtl/ex_mem_elastic_reg_pkg.sv
// Shared definitions for the EX/MEM elastic pipeline register.
// Provides the default PC width and the select encoding for the OUT entry's load source.
`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

package ex_mem_elastic_reg_pkg;

  // Source of the data loaded into the OUT entry on an edge.
  typedef enum logic [0:0] {
    OUT_SRC_INPUT = 1'b0,
    OUT_SRC_SKID  = 1'b1
  } out_src_e;

endpackage

// File: rtl/ex_mem_entry_reg.sv
// One bundle-wide pipeline entry: a load-enabled data register plus a valid bit.
// State updates on the falling clock edge, like the other stage registers.
// Reset clears everything. A clear drops only the valid bit and leaves the data in place.
module ex_mem_entry_reg #(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o
);

  logic [W-1:0] data_q;
  logic         valid_q;

  // Entry storage: reset > clear > load; the enable freezes the entry.
  always_ff @(negedge clock_i) begin
    if (reset_i) begin
      data_q  <= {W{1'b0}};
      valid_q <= 1'b0;
    end else if (enable_i) begin
      if (clear_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else begin
        valid_q <= valid_q;
      end
    end else begin
      valid_q <= valid_q;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ex_mem_elastic_reg.sv
// EX/MEM pipeline register with valid/ready handshake and 2-entry skid buffer.
// Adds flush, bubble control zeroing, a sticky halt flag and a saturating stall counter.
module ex_mem_elastic_reg
  import ex_mem_elastic_reg_pkg::*;
#(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int NB_MEM_CTRL = 6,
  parameter int NB_WB_CTRL  = 3,
  parameter int NB_ADDR     = `ADDRWIDTH,
  parameter int NB_CNT      = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_pipe_i,
  input  logic                   flush_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [NB_DATA-1:0]     alu_result_i,
  input  logic [NB_DATA-1:0]     data_write_i,
  input  logic [NB_DATA-1:0]     data_inm_i,
  input  logic [NB_REG-1:0]      write_register_i,
  input  logic [NB_ADDR-1:0]     pc_i,
  input  logic [NB_MEM_CTRL-1:0] MEM_control_i,
  input  logic [NB_WB_CTRL-1:0]  WB_control_i,
  input  logic                   halt_detected_i,
  output logic [NB_DATA-1:0]     alu_result_o,
  output logic [NB_DATA-1:0]     data_write_o,
  output logic [NB_DATA-1:0]     data_inm_o,
  output logic [NB_REG-1:0]      write_register_o,
  output logic [NB_ADDR-1:0]     pc_o,
  output logic [NB_MEM_CTRL-1:0] MEM_control_o,
  output logic [NB_WB_CTRL-1:0]  WB_control_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   reg_write_o,
  output logic                   halt_detected_o,
  output logic [NB_CNT-1:0]      stall_count_o
);

  localparam int WB_REGWRITE_BIT = NB_WB_CTRL - 1;
  localparam int NB_BUNDLE = 3 * NB_DATA + NB_REG + NB_ADDR + NB_MEM_CTRL + NB_WB_CTRL;

  logic [NB_BUNDLE-1:0] in_bundle_s;
  logic [NB_BUNDLE-1:0] out_bundle_s;
  logic [NB_BUNDLE-1:0] skid_bundle_s;
  logic [NB_BUNDLE-1:0] out_load_data_s;
  logic                 out_valid_s;
  logic                 skid_valid_s;
  logic                 acc_s;
  logic                 ret_s;
  logic                 out_load_s;
  logic                 out_clr_s;
  logic                 skid_load_s;
  logic                 skid_clr_s;
  out_src_e             out_src_s;

  logic                 halt_seen_q;
  logic                 halt_seen_d;
  logic [NB_CNT-1:0]    stall_q;
  logic [NB_CNT-1:0]    stall_d;

  logic [NB_DATA-1:0]     alu_s;
  logic [NB_DATA-1:0]     dwr_s;
  logic [NB_DATA-1:0]     inm_s;
  logic [NB_REG-1:0]      wreg_s;
  logic [NB_ADDR-1:0]     pc_s;
  logic [NB_MEM_CTRL-1:0] mem_s;
  logic [NB_WB_CTRL-1:0]  wb_s;

  assign in_bundle_s = {alu_result_i, data_write_i, data_inm_i, write_register_i,
                        pc_i, MEM_control_i, WB_control_i};

  // ready_o depends only on registered state and the enable, never on valid_i/ready_i.
  assign ready_o = enable_pipe_i & ~skid_valid_s & ~halt_seen_q;
  assign acc_s   = valid_i & ready_o;
  assign ret_s   = out_valid_s & ready_i & enable_pipe_i;

  // Handshake steering: decide which entries load or clear on this edge.
  always_comb begin
    out_load_s  = 1'b0;
    out_clr_s   = 1'b0;
    skid_load_s = 1'b0;
    skid_clr_s  = 1'b0;
    out_src_s   = OUT_SRC_INPUT;
    if (flush_i) begin
      out_clr_s  = 1'b1;
      skid_clr_s = 1'b1;
    end else if (!out_valid_s) begin
      out_load_s = acc_s;
    end else if (ret_s && skid_valid_s) begin
      out_load_s = 1'b1;
      out_src_s  = OUT_SRC_SKID;
      skid_clr_s = 1'b1;
    end else if (ret_s) begin
      if (acc_s) begin
        out_load_s = 1'b1;
      end else begin
        out_clr_s = 1'b1;
      end
    end else begin
      skid_load_s = acc_s;
    end
  end

  assign out_load_data_s = (out_src_s == OUT_SRC_SKID) ? skid_bundle_s : in_bundle_s;

  ex_mem_entry_reg #(.W(NB_BUNDLE)) u_out_entry (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .enable_i (enable_pipe_i),
    .clear_i  (out_clr_s),
    .load_i   (out_load_s),
    .data_i   (out_load_data_s),
    .data_o   (out_bundle_s),
    .valid_o  (out_valid_s)
  );

  ex_mem_entry_reg #(.W(NB_BUNDLE)) u_skid_entry (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .enable_i (enable_pipe_i),
    .clear_i  (skid_clr_s),
    .load_i   (skid_load_s),
    .data_i   (in_bundle_s),
    .data_o   (skid_bundle_s),
    .valid_o  (skid_valid_s)
  );

  // Next state for the sticky halt flag and the saturating stall counter.
  always_comb begin
    halt_seen_d = halt_seen_q;
    stall_d     = stall_q;
    if (acc_s && halt_detected_i && !flush_i) begin
      halt_seen_d = 1'b1;
    end else begin
      halt_seen_d = halt_seen_q;
    end
    if (out_valid_s && !ready_i && enable_pipe_i && (stall_q != {NB_CNT{1'b1}})) begin
      stall_d = stall_q + {{(NB_CNT-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // Halt flag and stall counter registers; frozen while the pipe is disabled.
  always_ff @(negedge clock_i) begin
    if (reset_i) begin
      halt_seen_q <= 1'b0;
      stall_q     <= {NB_CNT{1'b0}};
    end else if (enable_pipe_i) begin
      halt_seen_q <= halt_seen_d;
      stall_q     <= stall_d;
    end else begin
      halt_seen_q <= halt_seen_q;
      stall_q     <= stall_q;
    end
  end

  assign {alu_s, dwr_s, inm_s, wreg_s, pc_s, mem_s, wb_s} = out_bundle_s;

  assign alu_result_o     = alu_s;
  assign data_write_o     = dwr_s;
  assign data_inm_o       = inm_s;
  assign write_register_o = wreg_s;
  assign pc_o             = pc_s;
  // Bubbles carry no MEM/WB side effects; data fields keep their last value.
  assign MEM_control_o    = out_valid_s ? mem_s : {NB_MEM_CTRL{1'b0}};
  assign WB_control_o     = out_valid_s ? wb_s  : {NB_WB_CTRL{1'b0}};
  assign valid_o          = out_valid_s;
  assign reg_write_o      = wb_s[WB_REGWRITE_BIT] & out_valid_s;
  assign halt_detected_o  = halt_seen_q;
  assign stall_count_o    = stall_q;

endmodule

// File: doc/ex_mem_elastic_reg.md
# ex_mem_elastic_reg

Parametrised successor to the fixed EX/MEM pipeline register. It carries the EX-stage result bundle (ALU result, store data, LUI immediate, destination register, PC, MEM/WB control, halt flag) into the MEM stage through a valid/ready handshake with a 2-entry skid buffer. It adds stage flush, bubble insertion with control zeroing, a sticky halt, and a saturating stall counter. It sits between the EX stage and the data-memory stage, and its handshake allows a multi-cycle memory to back-pressure EX.

## Interface
Parameters:
- NB_DATA, 32, width of ALU result, store data, immediate
- NB_REG, 5, destination register index width
- NB_MEM_CTRL, 6, MEM control bundle width
- NB_WB_CTRL, 3, WB control bundle width; bit NB_WB_CTRL-1 is reg-write
- NB_ADDR, `ADDRWIDTH, PC width
- NB_CNT, 32, stall counter width

Ports:
- Clock and reset (already decided): one clock, clock_i; synchronous, active-high reset, reset_i.
- clock_i  in  1  single clock; all state updates on its falling edge (core pipeline-register convention)
- reset_i  in  1  synchronous active-high reset
- enable_pipe_i  in  1  debug-unit step enable; 0 freezes all state
- flush_i  in  1  discard all buffered entries
- valid_i  in  1  EX presents a bundle
- ready_o  out  1  stage can accept
- alu_result_i / alu_result_o  in/out  NB_DATA  ALU result
- data_write_i / data_write_o  in/out  NB_DATA  store data
- data_inm_i / data_inm_o  in/out  NB_DATA  LUI immediate
- write_register_i / write_register_o  in/out  NB_REG  destination register
- pc_i / pc_o  in/out  NB_ADDR  PC of instruction
- MEM_control_i / MEM_control_o  in/out  NB_MEM_CTRL  MEM control
- WB_control_i / WB_control_o  in/out  NB_WB_CTRL  WB control
- halt_detected_i  in  1  instruction is HALT
- valid_o  out  1  output entry valid
- ready_i  in  1  MEM stage accepts
- reg_write_o  out  1  WB_control_o[NB_WB_CTRL-1] & valid_o
- halt_detected_o  out  1  sticky: a HALT has been accepted
- stall_count_o  out  NB_CNT  cycles spent back-pressured

## Operation
- Entries: OUT (drives outputs) and SKID. Each entry holds the full bundle plus a valid bit.
- Accept: acc = valid_i & ready_o. Retire: ret = valid_o & ready_i & enable_pipe_i.
- ready_o = enable_pipe_i & !SKID.valid & !halt_seen. It has no combinational path from ready_i or valid_i.
- Per edge, when enable_pipe_i=1 and no flush:
  - OUT empty, acc → the input loads into OUT.
  - OUT valid, ret, SKID empty, acc → the input loads into OUT.
  - OUT valid, ret, SKID empty, no acc → OUT.valid clears.
  - OUT valid, ret, SKID full → SKID moves to OUT and SKID clears. acc is impossible here.
  - OUT valid, no ret, acc → the input loads into SKID.
- Bubble: when valid_o=0, MEM_control_o and WB_control_o read 0. The data fields hold their last value.
- flush_i=1 (with enable_pipe_i=1): both valid bits clear. Any simultaneous acc is dropped and any ret still completes. halt_seen is not cleared.
- halt_seen sets when an accepted bundle has halt_detected_i=1. It clears only on reset. halt_detected_o = halt_seen. Entries already buffered still drain.
- stall_count increments when valid_o & !ready_i & enable_pipe_i. It saturates at all-ones.
- enable_pipe_i=0: nothing changes (counter included), ready_o=0, and the outputs hold.
- Reset: both valid bits, all bundle fields, halt_seen and stall_count go to 0. Every output reads 0 except ready_o, which is 1 if enable_pipe_i=1.

## Timing
- Latency: a bundle accepted at falling edge N is visible on the outputs after edge N (same half-cycle register behaviour as the other stage registers).
- Throughput: 1 bundle per cycle while ready_i=1.
- Back-pressure: after the first stalled cycle, SKID fills and ready_o falls at the next edge. At most 2 bundles are buffered.
- Reset has priority over flush_i, and flush_i has priority over enable-gated updates. A reset mid-stall discards both entries.

## Structure
- `ADDRWIDTH and a WB_REGWRITE_BIT localparam go in parameters.vh.
- Sub-module: ex_mem_entry_reg, a load-enabled bundle register with valid bit and synchronous clear. It is instantiated twice (OUT, SKID).
- Top level holds the handshake control, halt_seen and the counter.

## Test plan
- Reset, then stream 4 bundles with ready_i=1 → valid_o high 4 cycles, pc_o 0x0,0x4,0x8,0xC in order, stall_count_o=0.
- Bundle A (alu_result 0x11) held while ready_i=0, B (0x22) offered → B goes to SKID, ready_o=0 next cycle. ready_i=1 → 0x11 then 0x22 out, no loss or duplicate, stall_count_o=2.
- flush_i with 2 entries buffered → valid_o=0, MEM_control_o=0, WB_control_o=0, reg_write_o=0 on next edge.
- HALT bundle accepted → halt_detected_o=1 and ready_o=0 thereafter. Prior buffered bundle still drains. flush_i leaves halt_detected_o=1. Only reset clears it.
- enable_pipe_i=0 for 3 cycles mid-stream with valid_i=1 → outputs and stall_count_o frozen, ready_o=0. On resume the sequence continues without loss.
- stall_count preloaded near max with NB_CNT=4 and 20 stalled cycles → stall_count_o saturates at 0xF.
